// File: rtl/frv_asi_issue.sv
// frv_asi_issue: single-outstanding issue stage in front of the ASI unit.
//   Decode side : s_valid/s_ready handshake with uop, rs1, rs2, shamt and rd.
//   ASI side    : asi_valid/asi_ready request with captured operands, and asi_result in.
//                 asi_flush_* are the state-flush controls.
//   WB side     : wb_valid/wb_ready handshake with wb_rd and wb_result.
//   flush       : pipeline flush. It aborts any op and returns the block to IDLE.
//   lat_count   : number of BUSY cycles of the current or most recent op.
module frv_asi_issue #(
  parameter int XLEN = 32,
  parameter int OPW  = 7
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  // decode-side issue
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [OPW-1:0]  s_uop,
  input  logic [XLEN-1:0] s_rs1,
  input  logic [XLEN-1:0] s_rs2,
  input  logic [1:0]      s_shamt,
  input  logic [4:0]      s_rd,
  // ASI unit
  output logic            asi_valid,
  input  logic            asi_ready,
  output logic [OPW-1:0]  asi_uop,
  output logic [XLEN-1:0] asi_rs1,
  output logic [XLEN-1:0] asi_rs2,
  output logic [1:0]      asi_shamt,
  input  logic [XLEN-1:0] asi_result,
  output logic            asi_flush_aessub,
  output logic            asi_flush_aesmix,
  output logic [31:0]     asi_flush_data,
  // writeback
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic [7:0]      lat_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [OPW-1:0]    uop_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, res_q;
  logic [1:0]        shamt_q;
  logic [4:0]        rd_q;
  logic [7:0]        lat_q, lat_d;
  logic              issue, capture;

  // In DONE, a new op can be accepted in the same cycle the result retires.
  assign s_ready = (state_q == IDLE) || (state_q == DONE && wb_ready);
  assign issue   = s_valid && s_ready && !flush;
  assign capture = (state_q == BUSY) && asi_ready && !flush;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (issue) state_d = BUSY;
        BUSY:    if (asi_ready) state_d = DONE;
        DONE:    if (wb_ready) state_d = issue ? BUSY : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The count is 1 on the first BUSY cycle. It increases only while the block stays in BUSY.
  // As a result, a single-cycle op reports a latency of 1.
  always_comb begin
    lat_d = lat_q;
    if (issue)
      lat_d = 8'd1;
    else if (state_q == BUSY && state_d == BUSY && lat_q != 8'hFF)
      lat_d = lat_q + 8'd1;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      uop_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (issue) begin
        uop_q   <= s_uop;
        rs1_q   <= s_rs1;
        rs2_q   <= s_rs2;
        shamt_q <= s_shamt;
        rd_q    <= s_rd;
      end
      if (capture) res_q <= asi_result;
    end
  end

  assign asi_valid        = (state_q == BUSY);
  assign asi_uop          = uop_q;
  assign asi_rs1          = rs1_q;
  assign asi_rs2          = rs2_q;
  assign asi_shamt        = shamt_q;
  assign asi_flush_aessub = flush && (state_q == BUSY);
  assign asi_flush_aesmix = flush && (state_q == BUSY);
  assign asi_flush_data   = 32'h0;

  assign wb_valid  = (state_q == DONE);
  assign wb_rd     = rd_q;
  assign wb_result = res_q;
  assign lat_count = lat_q;

endmodule
